// File: rtl/fsm_parallel_tiled.sv
// ----------------------------------------------------------------------------
// fsm_parallel_tiled
//   Controller for an N-lane tiled matrix/vector datapath. A job produces
//   m_cfg output rows; each row is built from k_cfg column tiles. For every
//   row the FSM clears the accumulators (LOAD), accumulates one tile per
//   accepted operand beat (COMPUTE), then presents the row result to the sink
//   (WRITE). A single-cycle done pulse closes the job.
//
// Ports
//   clk           : clock, rising-edge active
//   rst           : asynchronous active-high reset
//   start         : job request, sampled only in IDLE
//   m_cfg, k_cfg  : rows per job / tiles per row, latched (saturated) on start
//   operand_valid : tile operands present; low stalls COMPUTE
//   result_ready  : sink accepts the row result in WRITE
//   abort         : (FSM_PARALLEL_TILED_ABORT_EN only) cancel the running job
//   busy, done    : job in progress / job-complete pulse
//   row_idx       : current row
//   tile_idx      : current tile
//   acc_clr       : clear accumulators
//   acc_en        : accumulate current tile
//   wr_en         : row result valid
//   lanes         : constant N
//   acc_width     : constant accumulator width 2*WIDTH+clog2(K_MAX*N+1)
//
// Build option
//   FSM_PARALLEL_TILED_ABORT_EN : adds the abort input.
// ----------------------------------------------------------------------------
module fsm_parallel_tiled #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int M_MAX = 8,
  parameter int K_MAX = 4,
  localparam int RW   = (M_MAX > 1) ? $clog2(M_MAX) : 1,
  localparam int KW   = (K_MAX > 1) ? $clog2(K_MAX) : 1,
  localparam int MCW  = $clog2(M_MAX + 1),
  localparam int KCW  = $clog2(K_MAX + 1),
  localparam int LW   = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [MCW-1:0] m_cfg,
  input  logic [KCW-1:0] k_cfg,
  input  logic           operand_valid,
  input  logic           result_ready,
`ifdef FSM_PARALLEL_TILED_ABORT_EN
  input  logic           abort,
`endif
  output logic           busy,
  output logic           done,
  output logic [RW-1:0]  row_idx,
  output logic [KW-1:0]  tile_idx,
  output logic           acc_clr,
  output logic           acc_en,
  output logic           wr_en,
  output logic [LW-1:0]  lanes,
  output logic [7:0]     acc_width
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t         state;
  logic [MCW-1:0] m_lat;
  logic [KCW-1:0] k_lat;
  logic [MCW-1:0] m_sat;
  logic [KCW-1:0] k_sat;
  logic           last_tile;
  logic           last_row;
  logic           abort_req;

`ifdef FSM_PARALLEL_TILED_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Over-range configuration is clamped at latch time so the index counters
  // never run past the datapath dimensions.
  assign m_sat = (m_cfg > MCW'(M_MAX)) ? MCW'(M_MAX) : m_cfg;
  assign k_sat = (k_cfg > KCW'(K_MAX)) ? KCW'(K_MAX) : k_cfg;

  assign last_tile = (32'(tile_idx) + 32'd1) == 32'(k_lat);
  assign last_row  = (32'(row_idx) + 32'd1) == 32'(m_lat);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      m_lat    <= '0;
      k_lat    <= '0;
      row_idx  <= '0;
      tile_idx <= '0;
    end else if (abort_req && state != IDLE) begin
      state    <= IDLE;
      row_idx  <= '0;
      tile_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (m_cfg != '0 && k_cfg != '0) begin
              m_lat    <= m_sat;
              k_lat    <= k_sat;
              row_idx  <= '0;
              tile_idx <= '0;
              state    <= LOAD;
            end else begin
              state <= DONE;
            end
          end
        end
        LOAD: begin
          state <= COMPUTE;
        end
        COMPUTE: begin
          if (operand_valid) begin
            if (last_tile) state <= WRITE;
            else           tile_idx <= tile_idx + 1'b1;
          end
        end
        WRITE: begin
          if (result_ready) begin
            if (last_row) begin
              state    <= DONE;
              row_idx  <= '0;
              tile_idx <= '0;
            end else begin
              row_idx  <= row_idx + 1'b1;
              tile_idx <= '0;
              state    <= LOAD;
            end
          end
        end
        DONE: begin
          row_idx  <= '0;
          tile_idx <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status/strobe decode straight from the state register. acc_en is the one
  // strobe qualified by an input: it must coincide with the operand beat it
  // consumes, so it follows operand_valid in the same cycle.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    wr_en   = 1'b0;
    case (state)
      LOAD:    begin busy = 1'b1; acc_clr = 1'b1; end
      COMPUTE: begin busy = 1'b1; acc_en = operand_valid; end
      WRITE:   begin busy = 1'b1; wr_en = 1'b1; end
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  assign lanes     = LW'(N);
  assign acc_width = 8'(2 * WIDTH + $clog2(K_MAX * N + 1));

endmodule

// File: tb/tb_fsm_parallel_tiled.sv
// ----------------------------------------------------------------------------
// tb_fsm_parallel_tiled
//   Directed bench for fsm_parallel_tiled (default parameters). The FSM phase
//   is inferred from the decoded strobes: !busy=IDLE, acc_clr=LOAD,
//   wr_en=WRITE, done=DONE, otherwise COMPUTE. Inputs change 1 time unit after
//   a rising edge, outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_fsm_parallel_tiled;

  localparam int P_IDLE = 0, P_LOAD = 1, P_COMP = 2, P_WRITE = 3, P_DONE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] m_cfg;
  logic [2:0] k_cfg;
  logic       operand_valid;
  logic       result_ready;
`ifdef FSM_PARALLEL_TILED_ABORT_EN
  logic       abort;
`endif
  logic       busy, done, acc_clr, acc_en, wr_en;
  logic [2:0] row_idx;
  logic [1:0] tile_idx;
  logic [2:0] lanes;
  logic [7:0] acc_width;

  int n_checks = 0;
  int n_fail   = 0;

  fsm_parallel_tiled dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .m_cfg        (m_cfg),
    .k_cfg        (k_cfg),
    .operand_valid(operand_valid),
    .result_ready (result_ready),
`ifdef FSM_PARALLEL_TILED_ABORT_EN
    .abort        (abort),
`endif
    .busy         (busy),
    .done         (done),
    .row_idx      (row_idx),
    .tile_idx     (tile_idx),
    .acc_clr      (acc_clr),
    .acc_en       (acc_en),
    .wr_en        (wr_en),
    .lanes        (lanes),
    .acc_width    (acc_width)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int phase();
    if (!busy)  return P_IDLE;
    if (acc_clr) return P_LOAD;
    if (wr_en)  return P_WRITE;
    if (done)   return P_DONE;
    return P_COMP;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_ph   [10];
  int exp_row  [10];
  int exp_tile [10];

  initial begin
    rst = 1'b1; start = 1'b0; m_cfg = '0; k_cfg = '0;
    operand_valid = 1'b1; result_ready = 1'b1;
`ifdef FSM_PARALLEL_TILED_ABORT_EN
    abort = 1'b0;
`endif

    // Reset state, including a start request that must be ignored in reset.
    tick();
    start = 1'b1; m_cfg = 4'd2; k_cfg = 3'd2;
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_strobes", {acc_clr, acc_en, wr_en}, 0);
    check("rst_row", row_idx, 0);
    check("rst_tile", tile_idx, 0);
    check("lanes", lanes, 4);
    check("acc_width", acc_width, 21);
    start = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_after_rst", phase(), P_IDLE);

    // 2x3 job with no stalls; config and start toggled mid-job are ignored.
    exp_ph   = '{1, 2, 2, 2, 3, 1, 2, 2, 2, 3};
    exp_row  = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    exp_tile = '{0, 0, 1, 2, 0, 0, 0, 1, 2, 0};
    start = 1'b1; m_cfg = 4'd2; k_cfg = 3'd3;
    for (int i = 0; i < 10; i++) begin
      tick();
      start = (i < 9);
      m_cfg = 4'd5; k_cfg = 3'd1;
      check($sformatf("j23_phase_e%0d", i), phase(), exp_ph[i]);
      check($sformatf("j23_row_e%0d", i), row_idx, exp_row[i]);
      if (exp_ph[i] != P_WRITE)
        check($sformatf("j23_tile_e%0d", i), tile_idx, exp_tile[i]);
    end
    tick();
    check("j23_done_e10", done, 1);
    check("j23_done_row", row_idx, 0);
    check("j23_done_tile", tile_idx, 0);
    tick();
    check("j23_idle_e11", phase(), P_IDLE);
    check("j23_done_once", done, 0);

    // 1x2 job, operand_valid low for two cycles at tile 1: done at edge 6.
    start = 1'b1; m_cfg = 4'd1; k_cfg = 3'd2;
    tick(); start = 1'b0;
    check("stall_load", phase(), P_LOAD);
    tick();
    check("stall_c0", phase(), P_COMP);
    check("stall_acc_en0", acc_en, 1);
    tick();
    check("stall_t1", tile_idx, 1);
    operand_valid = 1'b0; #1;
    check("stall_acc_en_lo1", acc_en, 0);
    tick();
    check("stall_hold1_phase", phase(), P_COMP);
    check("stall_hold1_tile", tile_idx, 1);
    check("stall_acc_en_lo2", acc_en, 0);
    tick();
    check("stall_hold2_tile", tile_idx, 1);
    check("stall_hold2_phase", phase(), P_COMP);
    operand_valid = 1'b1; #1;
    check("stall_acc_en_hi", acc_en, 1);
    tick();
    check("stall_write", phase(), P_WRITE);
    tick();
    check("stall_done_e6", done, 1);
    tick();

    // 2x1 job, sink back-pressure for 3 cycles in row 0's WRITE.
    start = 1'b1; m_cfg = 4'd2; k_cfg = 3'd1; result_ready = 1'b0;
    tick(); start = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("bp_wr_en_%0d", i), wr_en, 1);
      check($sformatf("bp_row_%0d", i), row_idx, 0);
    end
    result_ready = 1'b1;
    tick();
    check("bp_load_row1", phase(), P_LOAD);
    check("bp_load_row1_idx", row_idx, 1);
    tick(); tick();
    check("bp_write_row1", wr_en, 1);
    check("bp_write_row1_idx", row_idx, 1);
    tick();
    check("bp_done", done, 1);
    tick();

    // Zero configuration: straight to DONE with no datapath strobes.
    start = 1'b1; m_cfg = 4'd3; k_cfg = 3'd0;
    tick(); start = 1'b0;
    check("k0_done", done, 1);
    check("k0_strobes", {acc_clr, acc_en, wr_en}, 0);
    tick();
    check("k0_idle", phase(), P_IDLE);
    start = 1'b1; m_cfg = 4'd0; k_cfg = 3'd2;
    tick(); start = 1'b0;
    check("m0_done", done, 1);
    check("m0_strobes", {acc_clr, acc_en, wr_en}, 0);
    tick();

    // k_cfg=7 saturates to K_MAX=4: tiles 0..3, WRITE at edge 5, done at 6.
    start = 1'b1; m_cfg = 4'd1; k_cfg = 3'd7;
    tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    check("sat_tile3", tile_idx, 3);
    check("sat_comp", phase(), P_COMP);
    tick();
    check("sat_write_e5", phase(), P_WRITE);
    tick();
    check("sat_done_e6", done, 1);
    tick();

    // Reset mid-COMPUTE of a 2x3 job aborts without a done pulse.
    start = 1'b1; m_cfg = 4'd2; k_cfg = 3'd3;
    tick(); start = 1'b0;
    tick(); tick();
    check("mid_rst_pre_tile", tile_idx, 1);
    rst = 1'b1; #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_idx", {row_idx, tile_idx}, 0);
    tick();
    check("mid_rst_no_done", done, 0);
    rst = 1'b0; start = 1'b1; m_cfg = 4'd1; k_cfg = 3'd1;
    tick(); start = 1'b0;
    check("post_rst_load", phase(), P_LOAD);
    check("post_rst_idx", {row_idx, tile_idx}, 0);
    tick(); tick();
    check("post_rst_write", phase(), P_WRITE);
    tick();
    check("post_rst_done", done, 1);
    tick();

`ifdef FSM_PARALLEL_TILED_ABORT_EN
    // Abort in WRITE beats result_ready; restart afterwards is normal.
    start = 1'b1; m_cfg = 4'd1; k_cfg = 3'd1;
    tick(); start = 1'b0;
    tick(); tick();
    check("ab_write", phase(), P_WRITE);
    abort = 1'b1;
    tick(); abort = 1'b0;
    check("ab_idle", phase(), P_IDLE);
    check("ab_no_done", done, 0);
    check("ab_idx", {row_idx, tile_idx}, 0);
    tick();
    check("ab_still_no_done", done, 0);
    start = 1'b1;
    tick(); start = 1'b0;
    check("ab_restart_load", phase(), P_LOAD);
    tick(); tick(); tick();
    check("ab_restart_done", done, 1);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
